seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Four-digit multiplexed seven-segment driver that sits directly downstream of the clock/alarm/stopwatch top level. It takes a 16-bit BCD word plus blink and alarm-flash controls and produces registered, active-low anode, segment and decimal-point drives. It also provides scan dead time, frame-coherent input latching and a shared blink timebase.

## Interface
- SCAN_DIV, 65536: clk cycles per digit slot (≥ DEAD+2).
- DEAD, 16: cycles at the start of each slot with all anodes off (anti-ghosting).
- BLINK_HALF, 25000000: clk cycles per blink half-period.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digits  in  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- blink_mask  in  4  bit i set: digit i blanked during blink-off phase.
- flash  in  1  alarm flash: all segments of all digits lit in on phase, blank in off phase.
- dp_en  in  4  bit i set: decimal point lit while digit i is driven.
- anode  out  4  active-low; anode[i] low selects digit i.
- seg  out  7  active-low; seg[0]=a … seg[6]=g.
- dp  out  1  active-low decimal point.
- digit_idx  out  2  digit currently scanned.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Scan counter counts 0..SCAN_DIV-1. At the terminal count it returns to 0 and digit_idx increments mod 4.
- Dead time: for scan counter < DEAD, anode=1111, seg=7'h7F, dp=1. Otherwise anode has bit digit_idx low and all others high.
- Frame latch: digits, blink_mask, dp_en and flash are sampled into shadow registers on the cycle digit_idx wraps 3→0, which is also the cycle frame_tick is high. A mid-frame input change is never displayed until the next frame.
- Blink counter counts 0..BLINK_HALF-1. At the terminal count, blink_phase toggles; 1 = on. This counter is independent of scan and free-running.
- Per-slot segment priority, highest first:
  - Dead time → blank.
  - Shadow flash → 7'h00 if blink_phase, else 7'h7F.
  - Blink-masked digit with blink_phase=0 → 7'h7F.
  - Otherwise the decoded nibble.
- Decode (active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Nibbles A–F → 7'h7F (blank).
- dp = ~shadow dp_en[digit_idx] outside dead time. dp is forced to 1 when the digit is blanked by blink or flash-off.
- Boundary cases:
  - Scan and blink terminal counts in the same cycle: both take effect independently.
  - flash and blink_mask both set: flash wins.

## Timing
- All outputs are registered. The output values for scan state N appear one clk after the counter reaches N.
- Reset (synchronous, takes effect at the next edge, also when asserted mid-slot or mid-frame):
  - Outputs: anode=1111, seg=7'h7F, dp=1, digit_idx=0, frame_tick=0.
  - Internal: scan counter=0, blink counter=0, blink_phase=1, shadow registers=0.
- The first frame after reset displays zeroed shadows (digits read "0000") until the first frame_tick latch.
- frame_tick period = 4·SCAN_DIV cycles. The first frame_tick comes 4·SCAN_DIV cycles after reset release.
- Counters must be wide enough for their parameters, i.e. $clog2 of SCAN_DIV and BLINK_HALF. No truncation is allowed at the terminal count.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: digit 3 is blanked when its shadow nibble is 0. Digit 2 is blanked when digits 3 and 2 are both 0. dp follows the normal rules. Digits 1 and 0 are never zero-suppressed.
  - Undefined: all zeros are displayed.

## Structure
- Shared package seg_pkg:
  - Segment constants SEG_0..SEG_9, SEG_BLANK (7'h7F), SEG_ALL (7'h00).
  - Anode one-hot table.
  - Digit-count constant (4).
- Sub-module bcd_seg_decode: combinational nibble → active-low 7-bit pattern with invalid → blank. Also reused by other display paths.

## Test plan
Parameters for all scenarios: SCAN_DIV=4, DEAD=1, BLINK_HALF=32.
1. Hold reset 3 cycles, then release → during reset anode=1111, seg=7'h7F, dp=1, digit_idx=0; first frame_tick 16 cycles after release.
2. digits=16'h1234, dp_en=0100 after the first frame_tick → digit 0 slot: anode=1110, seg=7'h19; digit 2 slot: dp=0; digit 3 slot: anode=0111, seg=7'h79; dead-time cycle of each slot: anode=1111.
3. digits=16'h0059, blink_mask=0001 → digit 0 shows 7'h10 while blink_phase=1; shows 7'h7F with dp=1 for the 32 cycles of blink_phase=0; digit 1 is unaffected (7'h12).
4. flash=1, blink_mask=1111 → every non-dead slot shows seg=7'h00 in the on phase and 7'h7F in the off phase.
5. digits changed from 16'h1111 to 16'h2222 in the middle of digit 1's slot → remaining slots of that frame still show 7'h79; 7'h24 appears from the slot after the next frame_tick.
6. digits=16'h00A5 → digit 1 blank; with LEADING_ZERO_BLANK_EN defined, digits 3 and 2 are also blank; without it they show 7'h40.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment constants, anode select table and display payload types.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NIBBLE_W   = 4;

    // Active-low patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_ALL   = 7'h00;

    // Active-low anode select, element i drives digit i
    localparam logic [NUM_DIGITS-1:0][NUM_DIGITS-1:0] ANODE_TBL =
        {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Frame-coherent copy of the display inputs
    typedef struct packed {
        logic [NUM_DIGITS*NIBBLE_W-1:0] digits;
        logic [NUM_DIGITS-1:0]          blink_mask;
        logic [NUM_DIGITS-1:0]          dp_en;
        logic                           flash;
    } frame_cfg_t;

    // One slot's worth of pad drive
    typedef struct packed {
        logic [NUM_DIGITS-1:0] anode;
        logic [SEG_W-1:0]      seg;
        logic                  dp;
    } disp_drive_t;

endpackage

// File: rtl/bcd_seg_decode.sv
// BCD nibble to active-low seven-segment pattern; non-decimal codes decode to blank.
module bcd_seg_decode
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] bcd,
    output logic [SEG_W-1:0]    seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with dead time, frame latching and blink.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros on digits 3 and 2.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 65536,
    parameter int unsigned DEAD       = 16,
    parameter int unsigned BLINK_HALF = 25000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    input  logic                          flash,
    input  logic [NUM_DIGITS-1:0]         dp_en,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [SEG_W-1:0]              seg,
    output logic                          dp,
    output logic [1:0]                    digit_idx,
    output logic                          frame_tick
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [SCAN_W-1:0]   scan_cnt;
    logic [1:0]          digit_cur;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    frame_cfg_t          shadow;

    logic                scan_tc_c;
    logic                frame_wrap_c;
    logic                blink_tc_c;
    logic                dead_c;
    logic                lz_blank_c;
    logic [NIBBLE_W-1:0] nibble_c;
    logic [SEG_W-1:0]    dec_seg_c;
    disp_drive_t         drive_c;

    always_comb begin
        scan_tc_c    = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
        frame_wrap_c = scan_tc_c && (digit_cur == 2'(NUM_DIGITS - 1));
        blink_tc_c   = (blink_cnt == BLINK_W'(BLINK_HALF - 1));
        dead_c       = (scan_cnt < SCAN_W'(DEAD));
        nibble_c     = shadow.digits[{digit_cur, 2'b00} +: NIBBLE_W];
    end

    // Slot counter and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_cur <= '0;
        end else if (scan_tc_c) begin
            scan_cnt  <= '0;
            digit_cur <= digit_cur + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // Free-running blink timebase, starts in the on phase
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_tc_c) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
    end

    // Inputs are captured only at the frame wrap so a frame never tears
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (frame_wrap_c) begin
            shadow <= '{digits: digits, blink_mask: blink_mask, dp_en: dp_en, flash: flash};
        end
    end

    bcd_seg_decode u_decode (
        .bcd   (nibble_c),
        .seg_c (dec_seg_c)
    );

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank_c = 1'b0;
        case (digit_cur)
            2'd3:    lz_blank_c = (shadow.digits[15:12] == 4'd0);
            2'd2:    lz_blank_c = (shadow.digits[15:8] == 8'd0);
            default: lz_blank_c = 1'b0;
        endcase
    end
`else
    always_comb begin
        lz_blank_c = 1'b0;
    end
`endif

    // Slot drive: dead time, then flash, then blink, then the decoded digit
    always_comb begin
        drive_c.anode = '1;
        drive_c.seg   = SEG_BLANK;
        drive_c.dp    = 1'b1;
        if (!dead_c) begin
            drive_c.anode = ANODE_TBL[digit_cur];
            drive_c.dp    = ~shadow.dp_en[digit_cur];
            if (shadow.flash) begin
                drive_c.seg = blink_phase ? SEG_ALL : SEG_BLANK;
                if (!blink_phase) begin
                    drive_c.dp = 1'b1;
                end
            end else if (shadow.blink_mask[digit_cur] && !blink_phase) begin
                drive_c.seg = SEG_BLANK;
                drive_c.dp  = 1'b1;
            end else if (lz_blank_c) begin
                drive_c.seg = SEG_BLANK;
            end else begin
                drive_c.seg = dec_seg_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anode      <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            anode      <= drive_c.anode;
            seg        <= drive_c.seg;
            dp         <= drive_c.dp;
            digit_idx  <= digit_cur;
            frame_tick <= frame_wrap_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with a short scan and blink period.
module tb_seg_scan_driver;

    logic        clk;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic        flash;
    logic [3:0]  dp_en;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    seg_scan_driver #(
        .SCAN_DIV   (4),
        .DEAD       (1),
        .BLINK_HALF (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .blink_mask (blink_mask),
        .flash      (flash),
        .dp_en      (dp_en),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release; state index shown at a negedge is cyc-1
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_frame: frame_tick got none in 64 cycles, want one");
        end
    endtask

    task automatic test_reset();
        int n;
        bit found;
        reset = 1'b1; digits = '0; blink_mask = '0; flash = 1'b0; dp_en = '0;
        repeat (3) @(negedge clk);
        total++; if (anode !== 4'hF)       begin bad++; $display("FAIL reset_anode got=%b want=1111", anode); end
        total++; if (seg !== 7'h7F)        begin bad++; $display("FAIL reset_seg got=%h want=7f", seg); end
        total++; if (dp !== 1'b1)          begin bad++; $display("FAIL reset_dp got=%b want=1", dp); end
        total++; if (digit_idx !== 2'd0)   begin bad++; $display("FAIL reset_digit_idx got=%0d want=0", digit_idx); end
        total++; if (frame_tick !== 1'b0)  begin bad++; $display("FAIL reset_frame_tick got=%b want=0", frame_tick); end
        reset = 1'b0;
        n = 0; found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin found = 1'b1; n = i; end
        end
        total++;
        if (n != 16) begin bad++; $display("FAIL first_frame_tick got=%0d cycles want=16", n); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [4];
        logic [3:0] ea;
        logic [6:0] es;
        logic       edp;
        int d, c;
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        digits = 16'h1234; dp_en = 4'b0100; blink_mask = '0; flash = 1'b0;
        wait_frame();
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            d = (s >> 2) & 3; c = s & 3;
            if (c == 0) begin
                ea = 4'hF; es = 7'h7F; edp = 1'b1;
            end else begin
                ea = ~(4'b0001 << d); es = exp_seg[d]; edp = (d == 2) ? 1'b0 : 1'b1;
            end
            if (s == 0) begin
                total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL tick_width got=%b want=0", frame_tick); end
            end
            total++; if (anode !== ea)      begin bad++; $display("FAIL scan_anode s=%0d got=%b want=%b", s, anode, ea); end
            total++; if (seg !== es)        begin bad++; $display("FAIL scan_seg s=%0d got=%h want=%h", s, seg, es); end
            total++; if (dp !== edp)        begin bad++; $display("FAIL scan_dp s=%0d got=%b want=%b", s, dp, edp); end
            total++; if (digit_idx !== 2'(d)) begin bad++; $display("FAIL scan_digit_idx s=%0d got=%0d want=%0d", s, digit_idx, d); end
        end
    endtask

    task automatic test_blink();
        int g, d, c;
        bit ph;
        logic [6:0] es;
        logic       edp;
        digits = 16'h0059; blink_mask = 4'b0001; dp_en = 4'b0001; flash = 1'b0;
        wait_frame();
        for (int s = 0; s < 64; s++) begin
            @(negedge clk);
            g = cyc - 1; d = (s >> 2) & 3; c = s & 3;
            ph = (((g >> 5) & 1) == 0);
            edp = 1'b1;
            if (c == 0)      es = 7'h7F;
            else if (d == 0) begin es = ph ? 7'h10 : 7'h7F; edp = ph ? 1'b0 : 1'b1; end
            else if (d == 1) es = 7'h12;
            else             es = LZ_SEG;
            total++; if (seg !== es) begin bad++; $display("FAIL blink_seg s=%0d phase=%0b got=%h want=%h", s, ph, seg, es); end
            total++; if (dp !== edp) begin bad++; $display("FAIL blink_dp s=%0d phase=%0b got=%b want=%b", s, ph, dp, edp); end
        end
    endtask

    task automatic test_flash();
        int g, d, c;
        bit ph;
        logic [6:0] es;
        logic [3:0] ea;
        digits = 16'h0059; blink_mask = 4'b1111; dp_en = 4'b0000; flash = 1'b1;
        wait_frame();
        for (int s = 0; s < 64; s++) begin
            @(negedge clk);
            g = cyc - 1; d = (s >> 2) & 3; c = s & 3;
            ph = (((g >> 5) & 1) == 0);
            if (c == 0) begin ea = 4'hF; es = 7'h7F; end
            else        begin ea = ~(4'b0001 << d); es = ph ? 7'h00 : 7'h7F; end
            total++; if (seg !== es)   begin bad++; $display("FAIL flash_seg s=%0d phase=%0b got=%h want=%h", s, ph, seg, es); end
            total++; if (anode !== ea) begin bad++; $display("FAIL flash_anode s=%0d got=%b want=%b", s, anode, ea); end
            total++; if (dp !== 1'b1)  begin bad++; $display("FAIL flash_dp s=%0d got=%b want=1", s, dp); end
        end
    endtask

    task automatic test_frame_latch();
        logic [6:0] es;
        digits = 16'h1111; blink_mask = '0; dp_en = '0; flash = 1'b0;
        wait_frame();
        for (int s = 0; s < 15; s++) begin
            @(negedge clk);
            es = ((s & 3) == 0) ? 7'h7F : 7'h79;
            total++; if (seg !== es) begin bad++; $display("FAIL latch_old_seg s=%0d got=%h want=%h", s, seg, es); end
            if (s == 6) digits = 16'h2222;
        end
        wait_frame();
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            es = ((s & 3) == 0) ? 7'h7F : 7'h24;
            total++; if (seg !== es) begin bad++; $display("FAIL latch_new_seg s=%0d got=%h want=%h", s, seg, es); end
        end
    endtask

    task automatic test_hex_lzb();
        logic [6:0] exp_seg [4];
        logic [6:0] es;
        exp_seg = '{7'h12, 7'h7F, LZ_SEG, LZ_SEG};
        digits = 16'h00A5; blink_mask = '0; dp_en = '0; flash = 1'b0;
        wait_frame();
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            es = ((s & 3) == 0) ? 7'h7F : exp_seg[(s >> 2) & 3];
            total++; if (seg !== es) begin bad++; $display("FAIL hex_seg s=%0d got=%h want=%h", s, seg, es); end
            total++; if (dp !== 1'b1) begin bad++; $display("FAIL hex_dp s=%0d got=%b want=1", s, dp); end
        end
    endtask

    initial begin
        reset = 1'b1; digits = '0; blink_mask = '0; flash = 1'b0; dp_en = '0;
        test_reset();
        test_scan();
        test_blink();
        test_flash();
        test_frame_latch();
        test_hex_lzb();
        repeat (5) @(negedge clk);
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
